if_stage_ctrl: RTL and testbench

IF_STAGE_CTRL -- requirements
Module: if_stage_ctrl

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/if_stage_ctrl.sv | 98 +++++++++
 tb/tb_if_stage_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF-stage state encoding.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline latch: bubble wins over enable, otherwise load when enabled.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  bubble_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic [PC_WIDTH-1:0]   pc_plus4_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [PC_WIDTH-1:0]   pc_plus4_o,
  output logic                  valid_o
);

  logic [INST_WIDTH-1:0] inst_q;
  logic [PC_WIDTH-1:0]   pc_plus4_q;
  logic                  valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_q     <= INST_WIDTH'(NOP_INST);
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (bubble_i) begin
      inst_q     <= INST_WIDTH'(NOP_INST);
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (en_i) begin
      inst_q     <= inst_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign inst_o     = inst_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch control: PC sequencing, flush/halt/stall/step handling,
// and the IF/ID latch. o_imem_addr is the next PC so memory data lines up with o_pc.
module if_stage_ctrl
  import pipeline_pkg::*;
#(
  parameter int                   PC_WIDTH   = 32,
  parameter int                   INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_PCWrite,
  input  logic                  i_if_id_write,
  input  logic                  i_flush,
  input  logic [PC_WIDTH-1:0]   i_flush_target,
  input  logic                  i_halt,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic [INST_WIDTH-1:0] i_imem_data,
  output logic [PC_WIDTH-1:0]   o_imem_addr,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic [INST_WIDTH-1:0] o_if_id_instruction,
  output logic [PC_WIDTH-1:0]   o_if_id_pc_plus4,
  output logic                  o_if_id_valid,
  output logic                  o_halted,
  output logic [31:0]           o_cycle_count
);

  if_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]         cnt_q, cnt_d;
  logic                advance, ifid_en, ifid_bubble;

  assign advance  = (state_q == ST_RUN) && (!i_step_mode || i_step);
  assign pc_plus4 = pc_q + PC_WIDTH'(PC_INC);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    ifid_en     = 1'b0;
    ifid_bubble = 1'b0;
    case (state_q)
      ST_FILL: state_d = ST_RUN;
      ST_RUN: begin
        if (advance) begin
          cnt_d = cnt_q + 32'd1;
          // Flush beats halt beats stall; halt leaves the PC on the HALT itself.
          if (i_flush) begin
            pc_d        = i_flush_target;
            ifid_bubble = 1'b1;
          end else if (i_halt) begin
            state_d     = ST_HALTED;
            ifid_bubble = 1'b1;
          end else begin
            if (i_PCWrite) pc_d = pc_plus4;
            ifid_en = i_if_id_write;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_FILL;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_if_id (
    .clk_i      (i_clock),
    .rst_ni     (i_reset),
    .en_i       (ifid_en),
    .bubble_i   (ifid_bubble),
    .inst_i     (i_imem_data),
    .pc_plus4_i (pc_plus4),
    .inst_o     (o_if_id_instruction),
    .pc_plus4_o (o_if_id_pc_plus4),
    .valid_o    (o_if_id_valid)
  );

  assign o_imem_addr   = pc_d;
  assign o_pc          = pc_q;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: fill, stall, flush, halt, reset, step mode, PC wrap.
module tb_if_stage_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pcw, ifw, flush, halt, smode, step;
  logic [31:0] target;
  logic [31:0] imem1, imem2, addr1, addr2, pc1, pc2, inst1, inst2, p41, p42, cnt1, cnt2;
  logic        vld1, vld2, hlt1, hlt2;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Synchronous-read instruction memory model, one cycle latency.
  always @(posedge clk) begin
    imem1 <= mem(addr1);
    imem2 <= mem(addr2);
  end

  if_stage_ctrl dut (
    .i_clock(clk), .i_reset(rst_n), .i_PCWrite(pcw), .i_if_id_write(ifw),
    .i_flush(flush), .i_flush_target(target), .i_halt(halt),
    .i_step_mode(smode), .i_step(step), .i_imem_data(imem1),
    .o_imem_addr(addr1), .o_pc(pc1), .o_if_id_instruction(inst1),
    .o_if_id_pc_plus4(p41), .o_if_id_valid(vld1), .o_halted(hlt1),
    .o_cycle_count(cnt1)
  );

  if_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clock(clk), .i_reset(rst_n), .i_PCWrite(pcw), .i_if_id_write(ifw),
    .i_flush(flush), .i_flush_target(target), .i_halt(halt),
    .i_step_mode(smode), .i_step(step), .i_imem_data(imem2),
    .o_imem_addr(addr2), .o_pc(pc2), .o_if_id_instruction(inst2),
    .o_if_id_pc_plus4(p42), .o_if_id_valid(vld2), .o_halted(hlt2),
    .o_cycle_count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pcw = 1'b1; ifw = 1'b1; flush = 1'b0; target = '0;
    halt = 1'b0; smode = 1'b0; step = 1'b0;
    tick(); tick();

    chk("rst_pc",    pc1, 32'h0);
    chk("rst_addr",  addr1, 32'h0);
    chk("rst_valid", 32'(vld1), 32'h0);
    chk("rst_inst",  inst1, 32'h0);
    chk("rst_p4",    p41, 32'h0);
    chk("rst_halt",  32'(hlt1), 32'h0);
    chk("rst_cnt",   cnt1, 32'h0);
    chk("wrap_rst_pc",   pc2, 32'hFFFF_FFFC);
    chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);

    rst_n = 1'b1;
    tick();                                  // FILL
    chk("fill_valid", 32'(vld1), 32'h0);
    chk("fill_pc",    pc1, 32'h0);
    chk("fill_cnt",   cnt1, 32'h0);
    tick();
    chk("run1_pc",    pc1, 32'h4);
    chk("run1_p4",    p41, 32'h4);
    chk("run1_inst",  inst1, mem(32'h0));
    chk("run1_valid", 32'(vld1), 32'h1);
    chk("wrap_pc",    pc2, 32'h0);
    chk("wrap_p4",    p42, 32'h0);
    chk("wrap_inst",  inst2, mem(32'hFFFF_FFFC));
    tick();
    chk("run2_pc",   pc1, 32'h8);
    chk("run2_p4",   p41, 32'h8);
    chk("run2_inst", inst1, mem(32'h4));
    chk("run2_cnt",  cnt1, 32'd2);

    // Two-cycle stall at PC=8
    pcw = 1'b0; ifw = 1'b0;
    #1 chk("stall_addr", addr1, 32'h8);
    tick(); tick();
    chk("stall_pc",   pc1, 32'h8);
    chk("stall_p4",   p41, 32'h8);
    chk("stall_inst", inst1, mem(32'h4));
    chk("stall_cnt",  cnt1, 32'd4);
    pcw = 1'b1; ifw = 1'b1;
    tick();
    chk("resume_pc",   pc1, 32'hC);
    chk("resume_p4",   p41, 32'hC);
    chk("resume_inst", inst1, mem(32'h8));

    // Flush with simultaneous stall
    flush = 1'b1; target = 32'h40; pcw = 1'b0; ifw = 1'b0;
    #1 chk("flush_addr", addr1, 32'h40);
    tick();
    chk("flush_pc",    pc1, 32'h40);
    chk("flush_valid", 32'(vld1), 32'h0);
    chk("flush_cnt",   cnt1, 32'd6);
    flush = 1'b0; pcw = 1'b1; ifw = 1'b1;
    tick();
    chk("postflush_p4",    p41, 32'h44);
    chk("postflush_inst",  inst1, mem(32'h40));
    chk("postflush_valid", 32'(vld1), 32'h1);

    // Flush beats halt, then halt at PC=0x10
    flush = 1'b1; target = 32'h10; halt = 1'b1;
    tick();
    chk("fvh_pc",   pc1, 32'h10);
    chk("fvh_halt", 32'(hlt1), 32'h0);
    flush = 1'b0;
    tick();
    chk("halt_flag",  32'(hlt1), 32'h1);
    chk("halt_pc",    pc1, 32'h10);
    chk("halt_valid", 32'(vld1), 32'h0);
    chk("halt_cnt",   cnt1, 32'd9);
    halt = 1'b0; flush = 1'b1; target = 32'h80;
    tick(); tick();
    chk("frozen_pc",   pc1, 32'h10);
    chk("frozen_cnt",  cnt1, 32'd9);
    chk("frozen_addr", addr1, 32'h10);
    chk("frozen_halt", 32'(hlt1), 32'h1);

    // Asynchronous reset from HALTED, checked without a clock edge
    rst_n = 1'b0; flush = 1'b0;
    #1;
    chk("arst_pc",    pc1, 32'h0);
    chk("arst_halt",  32'(hlt1), 32'h0);
    chk("arst_cnt",   cnt1, 32'h0);
    chk("arst_valid", 32'(vld1), 32'h0);
    chk("arst_addr",  addr1, 32'h0);
    tick();

    // Single-step: pulses on cycles 3 and 7; dropped flush on cycle 5
    smode = 1'b1; step = 1'b0;
    rst_n = 1'b1;
    tick();                                  // FILL
    for (int c = 1; c <= 8; c++) begin
      step   = (c == 3 || c == 7);
      flush  = (c == 5);
      target = 32'h80;
      tick();
      if (c == 3) begin
        chk("step3_pc",   pc1, 32'h4);
        chk("step3_inst", inst1, mem(32'h0));
        chk("step3_p4",   p41, 32'h4);
      end
      if (c == 5) chk("step5_pc", pc1, 32'h4);
    end
    step = 1'b0; flush = 1'b0;
    chk("step_pc",  pc1, 32'h8);
    chk("step_cnt", cnt1, 32'd2);
    chk("step_p4",  p41, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
